// File: rtl/amba3_apb_arbiter_pkg.sv
// Shared types for the AMBA 3 APB arbiter: FSM states, a transaction record for benches,
// and the default ACCESS-phase watchdog limit.
package pkg_amba3;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_arb_state_e;

  localparam int unsigned APB_ARB_TIMEOUT_CYCLES = 256;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        slverr;
    logic        timeout;
  } apb_arb_txn_t;

endpackage

// File: rtl/amba3_apb_arbiter_rr.sv
// Combinational round-robin picker: first asserted request after ptr, wrapping modulo NUM_REQ.
module amba3_apb_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_SIZE = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_SIZE-1:0] ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_SIZE-1:0] grant_id,
  output logic               grant_valid
);

  logic [ID_SIZE-1:0] idx;

  // Scan starts one past the last winner, so the previous winner has lowest priority.
  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_SIZE'((int'(ptr) + i) % NUM_REQ);
      if (en && !grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

endmodule

// File: rtl/amba3_apb_arbiter.sv
// Round-robin arbiter sharing one AMBA 3 APB master port among NUM_REQ requesters.
// Optional ACCESS-phase watchdog is compiled in by defining AMBA3_APB_ARBITER_TIMEOUT_EN.
module amba3_apb_arbiter
  import pkg_amba3::*;
#(
  parameter int ADDR_SIZE      = 32,
  parameter int DATA_SIZE      = 32,
  parameter int NUM_REQ        = 4,
  parameter int ID_SIZE        = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = APB_ARB_TIMEOUT_CYCLES
) (
  input  logic                         pclk,
  input  logic                         preset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ADDR_SIZE-1:0] req_addr,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_wdata,
  output logic                         rsp_valid,
  output logic [ID_SIZE-1:0]           rsp_id,
  output logic [DATA_SIZE-1:0]         rsp_rdata,
  output logic                         rsp_slverr,
  output logic                         rsp_timeout,
  output logic                         psel,
  output logic                         penable,
  output logic                         pwrite,
  output logic [ADDR_SIZE-1:0]         paddr,
  output logic [DATA_SIZE-1:0]         pwdata,
  input  logic                         pready,
  input  logic                         pslverr,
  input  logic [DATA_SIZE-1:0]         prdata
);

  apb_arb_state_e       state_q, state_d;
  logic [ID_SIZE-1:0]   last_grant_q, last_grant_d;
  logic [ID_SIZE-1:0]   id_q, id_d;
  logic [ADDR_SIZE-1:0] paddr_q, paddr_d;
  logic                 pwrite_q, pwrite_d;
  logic [DATA_SIZE-1:0] pwdata_q, pwdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ID_SIZE-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_slverr_q, rsp_slverr_d;
  logic                 rsp_timeout_q, rsp_timeout_d;

  logic [NUM_REQ-1:0]   grant;
  logic [ID_SIZE-1:0]   grant_id;
  logic                 grant_valid;
  logic                 timeout_hit;
  logic                 xfer_done;
  logic                 arb_en;

`ifdef AMBA3_APB_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_d == SETUP) begin
      tmo_cnt_d = '0;
    end else if (state_q == ACCESS) begin
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // The counter holds the number of ACCESS cycles already elapsed, so the last allowed one is LIMIT-1.
  assign timeout_hit = (state_q == ACCESS) && !pready &&
                       (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign xfer_done = (state_q == ACCESS) && (pready || timeout_hit);
  assign arb_en    = !preset && ((state_q == IDLE) || xfer_done);

  amba3_apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_SIZE (ID_SIZE)
  ) u_rr (
    .req         (req_valid),
    .ptr         (last_grant_q),
    .en          (arb_en),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    id_d          = id_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = xfer_done;
    rsp_id_d      = rsp_id_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE:    state_d = IDLE;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (xfer_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (xfer_done) begin
      rsp_id_d      = id_q;
      rsp_rdata_d   = (pready && !pwrite_q) ? prdata : '0;
      rsp_slverr_d  = pready ? pslverr : 1'b1;
      rsp_timeout_d = timeout_hit;
    end

    // A grant overrides the IDLE fall-back, giving back-to-back ACCESS -> SETUP.
    if (grant_valid) begin
      state_d      = SETUP;
      last_grant_d = grant_id;
      id_d         = grant_id;
      paddr_d      = req_addr[int'(grant_id)*ADDR_SIZE +: ADDR_SIZE];
      pwrite_d     = req_write[grant_id];
      pwdata_d     = req_wdata[int'(grant_id)*DATA_SIZE +: DATA_SIZE];
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q       <= IDLE;
      last_grant_q  <= ID_SIZE'(NUM_REQ - 1);
      id_q          <= '0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      id_q          <= id_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign req_ready   = grant;
  assign psel        = (state_q != IDLE);
  assign penable     = (state_q == ACCESS);
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_amba3_apb_arbiter.sv
// Bench for amba3_apb_arbiter: transaction-level reference model checked every cycle, plus
// directed scenarios with literal expectations. Timeout scenario runs when AMBA3_APB_ARBITER_TIMEOUT_EN is defined.
module tb_amba3_apb_arbiter;
  import pkg_amba3::*;

  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int IDW  = 2;
  localparam int TMO  = 8;
`ifdef AMBA3_APB_ARBITER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic               pclk = 1'b0;
  logic               preset = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ-1:0]    req_write = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic               rsp_valid, rsp_slverr, rsp_timeout;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_rdata, pwdata, prdata;
  logic               psel, penable, pwrite;
  logic [AW-1:0]      paddr;
  logic               pready = 1'b0;
  logic               pslverr;

  int n_cmp = 0;
  int n_fail = 0;

  int          pend[NREQ] = '{default: 0};
  int          glog[$];
  int          slv_wait = 0;
  int          acc_n = 0;
  logic        slv_err = 1'b0;
  logic [DW-1:0] slv_rdata = 32'hDEADBEEF;

  assign prdata  = slv_rdata;
  assign pslverr = slv_err;

  always #5 pclk = ~pclk;

  amba3_apb_arbiter #(
    .ADDR_SIZE      (AW),
    .DATA_SIZE      (DW),
    .NUM_REQ        (NREQ),
    .ID_SIZE        (IDW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .pclk        (pclk),
    .preset      (preset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_rdata   (rsp_rdata),
    .rsp_slverr  (rsp_slverr),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .prdata      (prdata)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight, its age in cycles since the grant edge.
  bit            cur_v = 1'b0;
  int            cur_id = 0;
  int            age = 0;
  int            m_last = NREQ - 1;
  logic [AW-1:0] m_paddr = '0;
  logic          m_pwrite = 1'b0;
  logic [DW-1:0] m_pwdata = '0;
  bit            m_rv = 1'b0;
  apb_arb_txn_t  m_rsp = '0;

  function automatic int pick(input logic [NREQ-1:0] v, input int from);
    for (int j = 1; j <= NREQ; j++) begin
      if (v[(from + j) % NREQ]) return (from + j) % NREQ;
    end
    return -1;
  endfunction

  function automatic bit modelDone();
    return cur_v && (age >= 1) && ((pready === 1'b1) || (TMO_EN && age >= TMO));
  endfunction

  function automatic bit modelArb();
    return !preset && (!cur_v || modelDone());
  endfunction

  always @(posedge pclk or posedge preset) begin
    if (preset) begin
      cur_v = 1'b0; age = 0; m_last = NREQ - 1;
      m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0;
      m_rv = 1'b0; m_rsp = '0;
    end else begin
      bit done, arb;
      int g;
      done = modelDone();
      arb  = modelArb();
      m_rv = done;
      if (done) begin
        m_rsp.id      = 4'(cur_id);
        m_rsp.rdata   = (pready && !m_pwrite) ? prdata : '0;
        m_rsp.slverr  = pready ? pslverr : 1'b1;
        m_rsp.timeout = !pready;
      end
      if (cur_v) age++;
      if (arb) begin
        g = pick(req_valid, m_last);
        if (g >= 0) begin
          cur_v = 1'b1; cur_id = g; age = 0; m_last = g;
          m_paddr  = req_addr[g*AW +: AW];
          m_pwrite = req_write[g];
          m_pwdata = req_wdata[g*DW +: DW];
        end else begin
          cur_v = 1'b0;
        end
      end
    end
  end

  always @(negedge pclk) begin
    logic [NREQ-1:0] exp_ready;
    int g;
    exp_ready = '0;
    if (modelArb()) begin
      g = pick(req_valid, m_last);
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    checkOutput("psel", psel, cur_v);
    checkOutput("penable", penable, cur_v && age >= 1);
    checkOutput("req_ready", req_ready, exp_ready);
    checkOutput("paddr", paddr, m_paddr);
    checkOutput("pwrite", pwrite, m_pwrite);
    checkOutput("pwdata", pwdata, m_pwdata);
    checkOutput("rsp_valid", rsp_valid, m_rv);
    if (m_rv) begin
      checkOutput("rsp_id", rsp_id, m_rsp.id);
      checkOutput("rsp_rdata", rsp_rdata, m_rsp.rdata);
      checkOutput("rsp_slverr", rsp_slverr, m_rsp.slverr);
      checkOutput("rsp_timeout", rsp_timeout, m_rsp.timeout);
    end
  end

  // Requesters hold valid until accepted; pend[i] counts requests still to issue.
  always @(posedge pclk) begin
    logic [NREQ-1:0] acc;
    acc = req_valid & req_ready;
    if (preset) acc = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        pend[i]--;
        glog.push_back(i);
      end
    end
    #1;
    for (int i = 0; i < NREQ; i++) req_valid[i] = (pend[i] > 0);
  end

  // Slave: pready after slv_wait extra ACCESS cycles.
  always @(posedge pclk or posedge preset) begin
    if (preset) begin
      acc_n  = 0;
      pready = 1'b0;
    end else begin
      #1;
      if (penable) begin
        acc_n++;
        pready = (acc_n > slv_wait);
      end else begin
        acc_n  = 0;
        pready = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input int i, input int cnt, input logic [AW-1:0] a,
                               input logic wr, input logic [DW-1:0] wd);
    req_addr[i*AW +: AW]  = a;
    req_write[i]          = wr;
    req_wdata[i*DW +: DW] = wd;
    pend[i]               = cnt;
  endtask

  int            n_psel, n_pen, n_wr;
  logic [IDW-1:0] got_id;
  logic [DW-1:0]  got_rdata;
  logic           got_err, got_tmo;

  task automatic waitResponse(input string tag, input int budget);
    bit seen;
    seen = 1'b0; n_psel = 0; n_pen = 0; n_wr = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge pclk);
      if (psel) n_psel++;
      if (penable) n_pen++;
      if (psel && pwrite) n_wr++;
      if (rsp_valid) begin
        seen = 1'b1;
        got_id = rsp_id; got_rdata = rsp_rdata; got_err = rsp_slverr; got_tmo = rsp_timeout;
      end
    end
    if (!seen) checkOutput({tag, "_rsp_wait"}, 64'd0, 64'd1);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge pclk);
      ok = !psel && !rsp_valid && (req_valid == '0) &&
           (pend[0] == 0) && (pend[1] == 0) && (pend[2] == 0) && (pend[3] == 0);
    end
    if (!ok) checkOutput({tag, "_idle_wait"}, 64'd0, 64'd1);
  endtask

  task automatic waitGrants(input string tag, input int n, input int budget);
    for (int k = 0; k < budget && glog.size() < n; k++) @(negedge pclk);
    if (glog.size() < n) checkOutput({tag, "_grant_wait"}, 64'(glog.size()), 64'(n));
  endtask

  task automatic waitSignal(input string tag, input bit want_penable, input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge pclk);
      ok = want_penable ? penable : psel;
    end
    if (!ok) checkOutput({tag, "_sig_wait"}, 64'd0, 64'd1);
  endtask

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    $display("[TB] starting amba3_apb_arbiter bench");
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    checkOutput("reset_psel", psel, 1'b0);
    checkOutput("reset_penable", penable, 1'b0);
    checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
    checkOutput("reset_paddr", paddr, 32'h0);
    @(posedge pclk);
    #3 preset = 1'b0;

    // Single read, two ACCESS cycles
    slv_wait = 1;
    applyStimulus(2, 1, 32'h1000, 1'b0, 32'h0);
    waitResponse("read", 50);
    checkOutput("read_psel_cycles", 64'(n_psel), 64'd3);
    checkOutput("read_penable_cycles", 64'(n_pen), 64'd2);
    checkOutput("read_rsp_id", got_id, 2'd2);
    checkOutput("read_rsp_rdata", got_rdata, 32'hDEADBEEF);
    checkOutput("read_rsp_slverr", got_err, 1'b0);
    checkOutput("read_paddr", paddr, 32'h1000);
    waitIdle("read", 50);

    // Write with slave error, zero wait
    slv_wait = 0;
    slv_err  = 1'b1;
    applyStimulus(0, 1, 32'h20, 1'b1, 32'h55AA);
    waitResponse("write", 50);
    checkOutput("write_pwrite_cycles", 64'(n_wr), 64'd2);
    checkOutput("write_psel_cycles", 64'(n_psel), 64'd2);
    checkOutput("write_pwdata", pwdata, 32'h55AA);
    checkOutput("write_rsp_slverr", got_err, 1'b1);
    checkOutput("write_rsp_rdata", got_rdata, 32'h0);
    checkOutput("write_rsp_id", got_id, 2'd0);
    slv_err = 1'b0;
    waitIdle("write", 50);

    // Reset in the middle of a stalled ACCESS
    slv_wait = 1000;
    applyStimulus(1, 1, 32'h300, 1'b0, 32'h0);
    waitSignal("rst_access", 1'b1, 50);
    applyStimulus(0, 1, 32'h400, 1'b0, 32'h0);
    applyStimulus(3, 1, 32'h700, 1'b1, 32'h77);
    glog.delete();
    repeat (3) @(posedge pclk);
    #3 preset = 1'b1;
    #1;
    checkOutput("rst_psel", psel, 1'b0);
    checkOutput("rst_penable", penable, 1'b0);
    checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
    slv_wait = 0;
    @(posedge pclk);
    @(posedge pclk);
    #3 preset = 1'b0;
    waitGrants("rst", 1, 20);
    if (glog.size() > 0) checkOutput("rst_first_grant", 64'(glog[0]), 64'd0);
    waitIdle("rst", 50);

    // Fairness with every requester asserting, zero-wait slave
    glog.delete();
    for (int i = 0; i < NREQ; i++)
      applyStimulus(i, 2, 32'h100 * (i + 1), ((i % 2) == 1), 32'hA0 + i);
    waitSignal("fair", 1'b0, 50);
    n_psel = 0;
    n_pen  = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge pclk);
      if (psel) n_psel++;
      if (penable) n_pen++;
    end
    checkOutput("fair_psel_cycles", 64'(n_psel), 64'd10);
    checkOutput("fair_penable_cycles", 64'(n_pen), 64'd5);
    waitGrants("fair", 5, 50);
    for (int k = 0; k < 5; k++) begin
      if (glog.size() > k) checkOutput($sformatf("fair_grant%0d", k), 64'(glog[k]), 64'(exp_order[k]));
    end
    waitIdle("fair", 200);

`ifdef AMBA3_APB_ARBITER_TIMEOUT_EN
    // Watchdog ends a transfer whose slave never answers
    slv_wait = 1000;
    applyStimulus(2, 1, 32'h44, 1'b0, 32'h0);
    waitResponse("tmo", 100);
    checkOutput("tmo_penable_cycles", 64'(n_pen), 64'd8);
    checkOutput("tmo_rsp_slverr", got_err, 1'b1);
    checkOutput("tmo_rsp_timeout", got_tmo, 1'b1);
    checkOutput("tmo_rsp_rdata", got_rdata, 32'h0);
    checkOutput("tmo_rsp_id", got_id, 2'd2);
    slv_wait = 0;
    waitIdle("tmo", 50);
    applyStimulus(1, 1, 32'h48, 1'b0, 32'h0);
    waitResponse("post_tmo", 50);
    checkOutput("post_tmo_timeout", got_tmo, 1'b0);
    checkOutput("post_tmo_id", got_id, 2'd1);
    checkOutput("post_tmo_rdata", got_rdata, 32'hDEADBEEF);
    waitIdle("post_tmo", 50);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] global watchdog expired");
  end

endmodule

// File: doc/amba3_apb_arbiter.md
Name: amba3_apb_arbiter

Overview:
- Shares one AMBA 3 APB master port between NUM_REQ independent requesters. Each requester has a valid/ready request channel and a broadcast response channel.
- Round-robin arbitration selects one request at a time. The block sequences the APB SETUP/ACCESS phases, waits on pready and returns prdata/pslverr tagged with the requester id.
- Sits between internal bus agents (CPU shim, DMA, debug) and a single APB slave segment.

Parameters:
- ADDR_SIZE, 32, paddr/req_addr width
- DATA_SIZE, 32, pwdata/prdata width
- NUM_REQ, 4, number of requesters, 2..16
- ID_SIZE, $clog2(NUM_REQ), rsp_id width
- TIMEOUT_CYCLES, 256, ACCESS-phase watchdog limit; used only with the optional feature

Ports:
- pclk  in  1  clock; one clock; reset is asynchronous and active-high
- preset  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_addr  in  NUM_REQ*ADDR_SIZE  packed addresses; requester i at [i*ADDR_SIZE +: ADDR_SIZE]
- req_write  in  NUM_REQ  1=write
- req_wdata  in  NUM_REQ*DATA_SIZE  packed write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_id  out  ID_SIZE  requester that owns the response
- rsp_rdata  out  DATA_SIZE  captured prdata; 0 for writes
- rsp_slverr  out  1  captured pslverr, or timeout
- rsp_timeout  out  1  response ended by watchdog; tied 0 when the feature is compiled out
- psel, penable, pwrite  out  1  APB control
- paddr  out  ADDR_SIZE  APB address
- pwdata  out  DATA_SIZE  APB write data
- pready, pslverr  in  1  APB slave status
- prdata  in  DATA_SIZE  APB read data

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, SETUP, ACCESS.
- Arbitration point: state==IDLE, or state==ACCESS && pready. The grant is the first asserted req_valid searching from last_grant+1 modulo NUM_REQ.
- req_ready is combinational: asserted for the granted index only at an arbitration point.
- At that clock edge: addr/write/wdata/id are registered into paddr/pwrite/pwdata and the id register; last_grant updates; next state is SETUP.
- No request at an arbitration point -> IDLE.
- Requester handshake: valid and fields must be held stable until ready. Deasserting valid before ready is allowed and is simply not granted.
- SETUP: psel=1, penable=0; always exactly one cycle, then ACCESS.
- ACCESS: psel=1, penable=1; held, with paddr/pwrite/pwdata stable, until pready=1.
- On the pready edge: rsp_valid=1 for the next cycle only.
  - rsp_rdata = prdata for reads, 0 for writes.
  - rsp_slverr = pslverr; rsp_id = served id.
- Back-to-back: a pending request granted on the pready cycle goes straight to SETUP. penable drops and psel stays 1 (legal APB3).
- Minimum read: accept edge T; SETUP cycle T+1; ACCESS T+2 with pready=1; rsp_valid in cycle T+3.
- Idle bus: psel=0, penable=0; paddr/pwdata hold their last values.
- Requesters never block on the response; rsp_valid is not back-pressured.
- Simultaneous events: a requester may be re-granted on the same cycle its own response is pending. Fairness then depends only on the pointer.
- Reset mid-transfer: everything clears immediately; the transfer is abandoned and no response is issued.

Optional Feature:
- Macro: AMBA3_APB_ARBITER_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in ACCESS. It is cleared on SETUP entry.
  - Counter reaching TIMEOUT_CYCLES without pready forces completion: psel/penable drop, and rsp_valid fires with rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
  - The arbitration point on that cycle behaves as a pready cycle.
- Undefined: no counter; ACCESS waits indefinitely; rsp_timeout is constant 0.

Decomposition:
- Package pkg_amba3 holds:
  - enum apb_arb_state_e {IDLE, SETUP, ACCESS};
  - the typedef for the request/response struct used by benches;
  - the default TIMEOUT_CYCLES localparam.
- One natural sub-module: amba3_apb_rr_arbiter (NUM_REQ).
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant plus encoded id; purely combinational.

Test Plan:
- Single read: req 2 valid, addr 0x1000; slave pready after 2 ACCESS cycles, prdata 0xDEADBEEF -> psel for 1+2 cycles; rsp_valid one cycle, rsp_id=2, rsp_rdata=0xDEADBEEF, rsp_slverr=0.
- Write with error: req 0 write addr 0x20, wdata 0x55AA; pready=1, pslverr=1 immediately -> pwdata=0x55AA, pwrite=1 in SETUP and ACCESS; rsp_slverr=1, rsp_rdata=0.
- Fairness: all 4 requesters valid continuously, zero-wait slave -> grant order 0,1,2,3,0; psel held high throughout, penable toggling every other cycle.
- Reset mid-ACCESS: preset pulses while pready=0 -> psel/penable/rsp_valid 0 asynchronously; after release requester 0 wins first.
- Timeout (macro defined, TIMEOUT_CYCLES=8): pready stuck 0 -> after 8 ACCESS cycles rsp_valid, rsp_slverr=1, rsp_timeout=1; next request proceeds normally.
